// File: rtl/id_microop_sequencer_if.sv
// Decode-stage <-> micro-op sequencer bus: ID-side instruction/status in, expanded micro-ops out.
interface id_microop_sequencer_if #(
  parameter int ADDR_W  = 32,
  parameter int REG_CNT = 16
);
  localparam int RIDX_W = $clog2(REG_CNT);

  logic [ADDR_W-1:0] instruction;
  logic              cond_pass;
  logic              hazard;
  logic              flush;

  logic              cycle_freeze;
  logic              uop_valid;
  logic              busy;
  logic [RIDX_W-1:0] uop_rd;
  logic [RIDX_W-1:0] uop_rn;
  logic [11:0]       uop_offset;
  logic              uop_mem_r;
  logic              uop_mem_w;
  logic              uop_wb_en;
  logic [3:0]        uop_exe_cmd;

  modport master (
    output instruction, cond_pass, hazard, flush,
    input  cycle_freeze, uop_valid, busy, uop_rd, uop_rn, uop_offset,
           uop_mem_r, uop_mem_w, uop_wb_en, uop_exe_cmd
  );

  modport slave (
    input  instruction, cond_pass, hazard, flush,
    output cycle_freeze, uop_valid, busy, uop_rd, uop_rn, uop_offset,
           uop_mem_r, uop_mem_w, uop_wb_en, uop_exe_cmd
  );
endinterface

// File: rtl/id_microop_sequencer.sv
// Expands LDM/STM block transfers held in ID into one memory micro-op per listed register.
// Define ID_MACRO_BASE_WB_EN to honour the W bit with a trailing base-register writeback micro-op.
module id_microop_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int REG_CNT = 16
) (
  input logic                   clk,
  input logic                   rst,
  id_microop_sequencer_if.slave bus
);
  localparam int RIDX_W = $clog2(REG_CNT);
  localparam int CNT_W  = RIDX_W + 1;

`ifdef ID_MACRO_BASE_WB_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, BASE_WB = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1} state_t;
`endif

  state_t             state;
  logic [REG_CNT-1:0] list_q;
  logic [RIDX_W-1:0]  rn_q;
  logic               l_q;
  logic               u_q;
`ifdef ID_MACRO_BASE_WB_EN
  logic               w_q;
`endif
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   k_q;

  logic [REG_CNT-1:0] list_in;
  logic [CNT_W-1:0]   cnt_in;
  logic               detect;
  logic               start;
  logic [RIDX_W-1:0]  low_idx;
  logic               last;
  logic [11:0]        off_inc;
  logic [11:0]        off_dec;
  logic [11:0]        off_wb;
  logic               unused_instr;

  assign list_in      = bus.instruction[REG_CNT-1:0];
  assign unused_instr = ^bus.instruction;

  always_comb begin
    cnt_in = '0;
    for (int unsigned i = 0; i < REG_CNT; i++) cnt_in = cnt_in + CNT_W'(list_in[i]);
  end

  always_comb begin
    low_idx = '0;
    for (int unsigned i = REG_CNT; i > 0; i--) if (list_q[i-1]) low_idx = RIDX_W'(i - 1);
  end

  assign detect  = (state == IDLE) && (bus.instruction[27:25] == 3'b100) &&
                   bus.cond_pass && !bus.hazard && !bus.flush;
  assign start   = detect && (cnt_in != '0);
  // Exactly one bit left means this issue is the last memory micro-op.
  assign last    = ~|(list_q & (list_q - REG_CNT'(1)));
  assign off_inc = 12'({k_q, 2'b00});
  assign off_dec = 12'({k_q, 2'b00}) - 12'({count_q, 2'b00});
  assign off_wb  = 12'({count_q, 2'b00});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      list_q  <= '0;
      rn_q    <= '0;
      l_q     <= 1'b0;
      u_q     <= 1'b0;
`ifdef ID_MACRO_BASE_WB_EN
      w_q     <= 1'b0;
`endif
      count_q <= '0;
      k_q     <= '0;
    end else if (bus.flush) begin
      state  <= IDLE;
      list_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= EXPAND;
          list_q  <= list_in;
          rn_q    <= bus.instruction[16 +: RIDX_W];
          l_q     <= bus.instruction[20];
          u_q     <= bus.instruction[23];
`ifdef ID_MACRO_BASE_WB_EN
          w_q     <= bus.instruction[21];
`endif
          count_q <= cnt_in;
          k_q     <= '0;
        end
        EXPAND: if (!bus.hazard) begin
          list_q <= list_q & (list_q - REG_CNT'(1));
          k_q    <= k_q + CNT_W'(1);
`ifdef ID_MACRO_BASE_WB_EN
          if (last) state <= w_q ? BASE_WB : IDLE;
`else
          if (last) state <= IDLE;
`endif
        end
`ifdef ID_MACRO_BASE_WB_EN
        BASE_WB: if (!bus.hazard) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from state and live inputs so hazard/flush/reset act in the same cycle.
  always_comb begin
    bus.cycle_freeze = 1'b0;
    bus.uop_valid    = 1'b0;
    bus.busy         = rst && (state != IDLE);
    bus.uop_rd       = '0;
    bus.uop_rn       = '0;
    bus.uop_offset   = '0;
    bus.uop_mem_r    = 1'b0;
    bus.uop_mem_w    = 1'b0;
    bus.uop_wb_en    = 1'b0;
    bus.uop_exe_cmd  = '0;
    if (rst && !bus.flush) begin
      case (state)
        IDLE: bus.cycle_freeze = start;
        EXPAND: begin
          if (bus.hazard) begin
            bus.cycle_freeze = 1'b1;
          end else begin
            bus.uop_valid   = 1'b1;
            bus.uop_rd      = low_idx;
            bus.uop_rn      = rn_q;
            bus.uop_offset  = u_q ? off_inc : off_dec;
            bus.uop_mem_r   = l_q;
            bus.uop_mem_w   = ~l_q;
            bus.uop_wb_en   = l_q;
            bus.uop_exe_cmd = 4'b0010;
`ifdef ID_MACRO_BASE_WB_EN
            bus.cycle_freeze = !last || w_q;
`else
            bus.cycle_freeze = !last;
`endif
          end
        end
`ifdef ID_MACRO_BASE_WB_EN
        BASE_WB: begin
          if (bus.hazard) begin
            bus.cycle_freeze = 1'b1;
          end else begin
            bus.uop_valid   = 1'b1;
            bus.uop_rd      = rn_q;
            bus.uop_rn      = rn_q;
            bus.uop_offset  = off_wb;
            bus.uop_wb_en   = 1'b1;
            bus.uop_exe_cmd = u_q ? 4'b0010 : 4'b0100;
          end
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_id_microop_sequencer.sv
// Randomized and directed bench for id_microop_sequencer against a list-expansion reference model.
module tb_id_microop_sequencer;
  typedef struct packed {
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [11:0] off;
    logic        mr;
    logic        mw;
    logic        wb;
    logic [3:0]  cmd;
  } uop_t;

  localparam logic [31:0] ADD_NOP = 32'hE0810002;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  uop_t exp_q[$];
  bit   fz_q[$];

  id_microop_sequencer_if #(.ADDR_W(32), .REG_CNT(16)) bus ();
  id_microop_sequencer #(.ADDR_W(32), .REG_CNT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_uop();
    uop_t u;
    u = '{rd: bus.uop_rd, rn: bus.uop_rn, off: bus.uop_offset, mr: bus.uop_mem_r,
          mw: bus.uop_mem_w, wb: bus.uop_wb_en, cmd: bus.uop_exe_cmd};
    return 32'(u);
  endfunction

  // Reference: the whole micro-op sequence an instruction should produce, in issue order.
  task automatic build(input logic [31:0] ins, input bit cond, input bit det_hz);
    int   cnt;
    int   k;
    uop_t u;
    exp_q.delete();
    fz_q.delete();
    if (ins[27:25] != 3'b100 || !cond || det_hz) return;
    cnt = $countones(ins[15:0]);
    if (cnt == 0) return;
    k = 0;
    for (int b = 0; b < 16; b++) begin
      if (ins[b]) begin
        u.rd  = 4'(b);
        u.rn  = ins[19:16];
        u.off = ins[23] ? 12'(4 * k) : 12'(4 * k - 4 * cnt);
        u.mr  = ins[20];
        u.mw  = !ins[20];
        u.wb  = ins[20];
        u.cmd = 4'b0010;
        exp_q.push_back(u);
        fz_q.push_back(1'b1);
        k++;
      end
    end
`ifdef ID_MACRO_BASE_WB_EN
    if (ins[21]) begin
      u = '{rd: ins[19:16], rn: ins[19:16], off: 12'(4 * cnt), mr: 1'b0, mw: 1'b0,
            wb: 1'b1, cmd: ins[23] ? 4'b0010 : 4'b0100};
      exp_q.push_back(u);
      fz_q.push_back(1'b1);
    end
`endif
    fz_q[fz_q.size() - 1] = 1'b0;
  endtask

  task automatic run_seq(input logic [31:0] ins, input bit cond, input bit det_hz,
                         input int hz_at, input int hz_len, input int flush_at, input bit rnd);
    int n = 0;
    int stalls = 0;
    int cyc = 0;
    bit hz;
    bit fl;
    build(ins, cond, det_hz);
    bus.instruction = ins;
    bus.cond_pass   = cond;
    bus.hazard      = det_hz;
    bus.flush       = 1'b0;
    #4;
    check("det_valid", 32'(bus.uop_valid), 32'd0);
    check("det_freeze", 32'(bus.cycle_freeze), 32'(exp_q.size() != 0));
    check("det_uop", obs_uop(), 32'd0);
    @(posedge clk); #1;
    if (exp_q.size() == 0) bus.instruction = ADD_NOP;
    while (exp_q.size() > 0) begin
      if (cyc > 200) begin
        check("timeout", 32'd1, 32'd0);
        exp_q.delete();
        break;
      end
      cyc++;
      hz = (n == hz_at && stalls < hz_len) || (rnd && $urandom_range(3) == 0);
      fl = (n == flush_at);
      bus.hazard = hz;
      bus.flush  = fl;
      #4;
      check("busy", 32'(bus.busy), 32'd1);
      if (fl) begin
        check("fl_valid", 32'(bus.uop_valid), 32'd0);
        check("fl_freeze", 32'(bus.cycle_freeze), 32'd0);
        check("fl_uop", obs_uop(), 32'd0);
        exp_q.delete();
      end else if (hz) begin
        if (n == hz_at) stalls++;
        check("hz_valid", 32'(bus.uop_valid), 32'd0);
        check("hz_freeze", 32'(bus.cycle_freeze), 32'd1);
        check("hz_uop", obs_uop(), 32'd0);
      end else begin
        check("valid", 32'(bus.uop_valid), 32'd1);
        check("freeze", 32'(bus.cycle_freeze), 32'(fz_q[0]));
        check("uop", obs_uop(), 32'(exp_q[0]));
        void'(exp_q.pop_front());
        void'(fz_q.pop_front());
        n++;
      end
      if (exp_q.size() == 0) bus.instruction = ADD_NOP;
      @(posedge clk); #1;
    end
    bus.hazard = 1'b0;
    bus.flush  = 1'b0;
    #4;
    check("end_busy", 32'(bus.busy), 32'd0);
    check("end_valid", 32'(bus.uop_valid), 32'd0);
    check("end_freeze", 32'(bus.cycle_freeze), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] ins;
    bus.instruction = 32'hE8B20029;
    bus.cond_pass   = 1'b1;
    bus.hazard      = 1'b0;
    bus.flush       = 1'b0;
    #1;
    check("rst_valid", 32'(bus.uop_valid), 32'd0);
    check("rst_freeze", 32'(bus.cycle_freeze), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_uop", obs_uop(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    bus.instruction = ADD_NOP;
    rst = 1'b1;
    @(posedge clk); #1;

    run_seq(32'hE8B20029, 1'b1, 1'b0, -1, 0, -1, 1'b0);
    run_seq(32'hE92D4010, 1'b1, 1'b0, -1, 0, -1, 1'b0);
    run_seq(32'hE8B20029, 1'b1, 1'b0, 1, 2, -1, 1'b0);
    run_seq(32'hE92D4010, 1'b1, 1'b0, -1, 0, 1, 1'b0);
    run_seq(32'hE8920000, 1'b1, 1'b0, -1, 0, -1, 1'b0);
    run_seq(32'hE0810002, 1'b1, 1'b0, -1, 0, -1, 1'b0);
    run_seq(32'hE8B20029, 1'b0, 1'b0, -1, 0, -1, 1'b0);
    run_seq(32'hE8B20029, 1'b1, 1'b1, -1, 0, -1, 1'b0);

    // Asynchronous reset in the middle of an expansion.
    bus.instruction = 32'hE8B20029;
    bus.cond_pass   = 1'b1;
    @(posedge clk); #1;
    bus.instruction = ADD_NOP;
    check("pre_rst_valid", 32'(bus.uop_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.uop_valid), 32'd0);
    check("mid_rst_freeze", 32'(bus.cycle_freeze), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_uop", obs_uop(), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_seq(32'hE8B20029, 1'b1, 1'b0, -1, 0, -1, 1'b0);

    for (int t = 0; t < 60; t++) begin
      ins = $urandom;
      if ($urandom_range(3) != 0) ins[27:25] = 3'b100;
      if ($urandom_range(4) == 0) ins[15:0] = '0;
      else ins[15:0] = ins[15:0] & 16'($urandom);
      run_seq(ins, $urandom_range(7) != 0, $urandom_range(9) == 0, -1, 0,
              ($urandom_range(5) == 0) ? int'($urandom_range(3)) : -1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/id_microop_sequencer.md
ID_MICROOP_SEQUENCER -- requirements
Module: id_microop_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, instruction width.
REQ-002 SHALL have parameter REG_CNT, default 16, register-list width (8 or 16); RIDX_W = clog2(REG_CNT).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port instruction  in  ADDR_W  word held in ID.
REQ-006 SHALL have port cond_pass  in  1  condition check passed for instruction.
REQ-007 SHALL have port hazard  in  1  stall from hazard unit.
REQ-008 SHALL have port flush  in  1  taken-branch flush.
REQ-009 SHALL have port cycle_freeze  out  1  hold PC and IF/ID register.
REQ-010 SHALL have ports uop_valid (out, 1) and busy (out, 1, state != IDLE).
REQ-011 SHALL have ports uop_rd, uop_rn  out  RIDX_W  micro-op dest and base register.
REQ-012 SHALL have port uop_offset  out  12  signed byte offset or ADD/SUB immediate.
REQ-013 SHALL have ports uop_mem_r, uop_mem_w, uop_wb_en  out  1 each, and uop_exe_cmd  out  4.

Function
REQ-014 SHALL detect a macro when instruction[27:25]==3'b100, cond_pass==1, hazard==0, flush==0, state IDLE; fields: U=[23], W=[21], L=[20], Rn=[19:16], list=[REG_CNT-1:0].
REQ-015 SHALL in the detect cycle latch list, Rn, L, U, W and count = popcount(list), drive uop_valid=0, cycle_freeze=1, and enter EXPAND on the next edge.
REQ-016 SHALL treat count==0 as NOP: stay IDLE, cycle_freeze=0, no micro-ops.
REQ-017 SHALL, per unstalled EXPAND cycle, issue one micro-op for the lowest set remaining bit k (k-th issued, 0-based): uop_valid=1, uop_rd=bit index, uop_rn=Rn, uop_mem_r=L, uop_mem_w=~L, uop_wb_en=L, uop_exe_cmd=4'b0010.
REQ-018 SHALL set uop_offset = 4*k when U=1 (increment-after), 4*k - 4*count when U=0 (decrement-before), two's complement in 12 bits.
REQ-019 SHALL clear the issued bit at the edge; after the last bit go to BASE_WB if W=1 (and macro enabled), else IDLE.
REQ-020 SHALL in BASE_WB issue uop_rd=Rn, uop_rn=Rn, uop_offset=4*count, uop_exe_cmd=4'b0010 (U=1) or 4'b0100 (U=0), uop_wb_en=1, mem enables 0, then return to IDLE.
REQ-021 SHALL drive cycle_freeze=1 in EXPAND except the cycle issuing the final micro-op of the sequence; 0 in BASE_WB and in IDLE outside detect.
REQ-022 SHALL, while hazard=1 in EXPAND/BASE_WB, drive uop_valid=0, cycle_freeze=1, and hold state and remaining list.
REQ-023 SHALL, on flush=1, drive uop_valid=0 and cycle_freeze=0 combinationally and enter IDLE at the next edge; flush overrides hazard and detect.
REQ-024 SHALL drive all uop_* outputs to 0 whenever uop_valid=0.
REQ-025 SHALL ignore non-macro instructions in IDLE: uop_valid=0, cycle_freeze=0.

Reset
REQ-026 SHALL on rst=0 asynchronously enter IDLE, clear latched fields and list, and drive every output 0, including mid-sequence.
REQ-027 SHALL resume detection on the first rising clk edge after rst rises.

Configuration
REQ-028 SHALL, with ID_MACRO_BASE_WB_EN defined, honour W and implement BASE_WB per REQ-020.
REQ-029 SHALL, without ID_MACRO_BASE_WB_EN, ignore W, omit BASE_WB, and drop cycle_freeze on the last memory micro-op.

Verification
REQ-030 SHALL test E8B20029 (LDMIA r2!,{r0,r3,r5}), macro on -> detect freeze=1; uops rd0/off0, rd3/off4, rd5/off8 mem_r wb_en; then rd2 off12 cmd0010; freeze 0 only in BASE_WB cycle.
REQ-031 SHALL test E92D4010 (STMDB r13!,{r4,r14}) -> rd4 off 0xFF8, rd14 off 0xFFC mem_w=1; then rd13 off8 cmd0100.
REQ-032 SHALL test hazard=1 for 2 cycles after first uop of REQ-030 -> two cycles uop_valid=0 freeze=1, then rd3/off4 reissued unchanged.
REQ-033 SHALL test flush=1 during second uop of REQ-031 -> uop_valid=0 same cycle, busy=0 next cycle, no BASE_WB.
REQ-034 SHALL test E8920000 (empty list) and E0810002 (ADD) -> uop_valid=0, cycle_freeze=0 throughout.
REQ-035 SHALL test rst=0 asserted mid-EXPAND between edges -> all outputs 0 immediately; later E8B20029 sequences normally.
